// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch stage (master)
// and the instruction cache/memory (slave).
interface fetch_unit_if;
    logic        IMem_Req;
    logic [15:0] IMem_Addr;
    logic [15:0] IMem_Data;
    logic        IMem_Valid;

    modport master (output IMem_Req, IMem_Addr, input  IMem_Data, IMem_Valid);
    modport slave  (input  IMem_Req, IMem_Addr, output IMem_Data, IMem_Valid);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the IF/ID register, tolerates
// multi-cycle memory misses, squashes wrong-path fetches and halts on HLT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  imem,
    input  logic          Stall,
    input  logic          PCDisrupt,
    input  logic [15:0]   PCBranch,
    output logic [15:0]   IFID_Instruction,
    output logic [15:0]   IFID_PC,
    output logic          IFID_Valid,
    output logic          IF_Busy,
    output logic          Fetch_Halted,
    output logic [15:0]   Miss_Count
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;

    state_t      state_q;
    logic [15:0] pc_q, redir_q, buf_q, miss_q;
    logic [15:0] ifid_instr_q, ifid_pc_q;
    logic        ifid_vld_q, squash_q;

    logic        redirect;
    logic        squash_eff;
    logic [15:0] redir_tgt;
    logic [15:0] acc_word;
    logic        acc_hlt;
    logic [15:0] pc_plus2;

    assign redirect   = PCDisrupt & ~Stall;
    // A redirect arriving in the same cycle as the returning word also kills it.
    assign squash_eff = squash_q | redirect;
    assign redir_tgt  = redirect ? PCBranch : redir_q;
    assign acc_word   = (state_q == HOLD) ? buf_q : imem.IMem_Data;
    assign acc_hlt    = (acc_word[15:12] == HLT_OPCODE);
    assign pc_plus2   = pc_q + 16'd2;

    // Gated by rst so an in-flight request is withdrawn the instant reset asserts.
    assign imem.IMem_Req  = rst & ((state_q == FETCH) | (state_q == WAIT));
    assign imem.IMem_Addr = pc_q;

    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_Valid       = ifid_vld_q;
    assign IF_Busy          = (state_q == WAIT);
    assign Fetch_Halted     = (state_q == HALTED);
    assign Miss_Count       = miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            redir_q      <= 16'h0000;
            squash_q     <= 1'b0;
            buf_q        <= 16'h0000;
            miss_q       <= 16'h0000;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 16'h0000;
            ifid_vld_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.IMem_Valid) begin
                        if (redirect) begin
                            ifid_instr_q <= NOP_INSTR;
                            ifid_pc_q    <= pc_q;
                            ifid_vld_q   <= 1'b0;
                            pc_q         <= PCBranch;
                        end else if (!Stall) begin
                            ifid_instr_q <= acc_word;
                            ifid_pc_q    <= pc_q;
                            ifid_vld_q   <= 1'b1;
                            if (acc_hlt) state_q <= HALTED;
                            else         pc_q    <= pc_plus2;
                        end
                    end else begin
                        state_q <= WAIT;
                        if (!Stall) begin
                            ifid_instr_q <= NOP_INSTR;
                            ifid_pc_q    <= pc_q;
                            ifid_vld_q   <= 1'b0;
                        end
                        if (redirect) begin
                            squash_q <= 1'b1;
                            redir_q  <= PCBranch;
                        end
                    end
                end
                WAIT: begin
                    if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
                    if (!Stall) begin
                        ifid_instr_q <= NOP_INSTR;
                        ifid_pc_q    <= pc_q;
                        ifid_vld_q   <= 1'b0;
                    end
                    if (redirect) begin
                        squash_q <= 1'b1;
                        redir_q  <= PCBranch;
                    end
                    if (imem.IMem_Valid) begin
                        squash_q <= 1'b0;
                        redir_q  <= 16'h0000;
                        if (squash_eff) begin
                            pc_q    <= redir_tgt;
                            state_q <= FETCH;
                        end else if (!Stall) begin
                            ifid_instr_q <= acc_word;
                            ifid_vld_q   <= 1'b1;
                            if (acc_hlt) state_q <= HALTED;
                            else begin
                                pc_q    <= pc_plus2;
                                state_q <= FETCH;
                            end
                        end else begin
                            buf_q   <= imem.IMem_Data;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        ifid_instr_q <= NOP_INSTR;
                        ifid_pc_q    <= pc_q;
                        ifid_vld_q   <= 1'b0;
                        pc_q         <= PCBranch;
                        state_q      <= FETCH;
                    end else if (!Stall) begin
                        ifid_instr_q <= acc_word;
                        ifid_pc_q    <= pc_q;
                        ifid_vld_q   <= 1'b1;
                        if (acc_hlt) state_q <= HALTED;
                        else begin
                            pc_q    <= pc_plus2;
                            state_q <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    if (!Stall) begin
                        ifid_instr_q <= NOP_INSTR;
                        ifid_pc_q    <= pc_q;
                        ifid_vld_q   <= 1'b0;
                    end
                    if (redirect) begin
                        pc_q    <= PCBranch;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule
